// File: rtl/ysyx_22040759_axi_pkg.sv
// Shared AXI read-path constants, FSM encoding and size helpers.
package ysyx_22040759_axi_pkg;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   // One-hot read-master FSM encoding
   localparam logic [3:0] ST_IDLE = 4'b0001;
   localparam logic [3:0] ST_ADDR = 4'b0010;
   localparam logic [3:0] ST_DATA = 4'b0100;
   localparam logic [3:0] ST_HOLD = 4'b1000;

   // Mask keeping the low (1 << size) bytes of a 64-bit word
   function automatic logic [63:0] f_size_mask(input logic [1:0] size);
      logic [63:0] mask;
      case (size)
         SIZE_B:  mask = 64'h0000_0000_0000_00FF;
         SIZE_H:  mask = 64'h0000_0000_0000_FFFF;
         SIZE_W:  mask = 64'h0000_0000_FFFF_FFFF;
         default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return mask;
   endfunction

   // True when the byte offset is not a multiple of the access size
   function automatic logic f_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
      logic bad;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = addr_lo[0];
         SIZE_W:  bad = |addr_lo[1:0];
         default: bad = |addr_lo;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ysyx_22040759_rdata_align.sv
// Shifts the 64-bit read beat down to the addressed byte lane and
// zero-extends it to the access size.
module ysyx_22040759_rdata_align
   import ysyx_22040759_axi_pkg::*;
(
   input  logic [63:0] i_rdata,
   input  logic [2:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   output logic [63:0] o_data
);

   logic [63:0] w_shifted;

   assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
   assign o_data    = w_shifted & f_size_mask(i_size);

endmodule

// File: rtl/ysyx_22040759_axi_rd_master.sv
// Single-outstanding AXI4 read master: turns one arbiter request into a
// single-beat AR/R transaction, returns aligned data with a one-cycle
// pulse, then holds off for HOLD_CYCLES so the arbiter can switch users.
module ysyx_22040759_axi_rd_master
   import ysyx_22040759_axi_pkg::*;
#(
   parameter logic [3:0]  AXI_ID      = 4'd0,
   parameter int unsigned HOLD_CYCLES = 3
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_addr_valid_i,
   input  logic [63:0] rd_addr_i,
   input  logic [1:0]  rd_size_i,
   output logic        rd_data_valid_o,
   output logic [63:0] rd_data_o,
   output logic        rd_err_o,
   output logic        axi_arvalid_o,
   input  logic        axi_arready_i,
   output logic [63:0] axi_araddr_o,
   output logic [3:0]  axi_arid_o,
   output logic [7:0]  axi_arlen_o,
   output logic [2:0]  axi_arsize_o,
   output logic [1:0]  axi_arburst_o,
   input  logic        axi_rvalid_i,
   output logic        axi_rready_o,
   input  logic [63:0] axi_rdata_i,
   input  logic [1:0]  axi_rresp_i,
   input  logic        axi_rlast_i,
   input  logic [3:0]  axi_rid_i
);

   localparam logic [2:0] LP_HOLD = HOLD_CYCLES[2:0];

   logic [3:0]  r_state;
   logic [63:0] r_addr;
   logic [1:0]  r_size;
   logic [2:0]  r_hold_cnt;
   logic        r_arvalid;
   logic        r_rready;
   logic        r_data_valid;
   logic        r_err;
   logic [63:0] r_data;

   logic [63:0] w_aligned;
   logic        w_misaligned;
   logic        w_resp_err;

   ysyx_22040759_rdata_align u_align (
      .i_rdata   (axi_rdata_i),
      .i_addr_lo (r_addr[2:0]),
      .i_size    (r_size),
      .o_data    (w_aligned)
   );

   assign w_misaligned = f_misaligned(rd_addr_i[2:0], rd_size_i);
   assign w_resp_err   = (axi_rresp_i != RESP_OKAY) || (axi_rid_i != AXI_ID) || !axi_rlast_i;

   // Request/AR/R sequencing, result capture and post-completion hold-off
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_size       <= '0;
         r_hold_cnt   <= '0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_data_valid <= 1'b0;
         r_err        <= 1'b0;
         r_data       <= '0;
      end else begin
         r_data_valid <= 1'b0;
         r_err        <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rd_addr_valid_i) begin
                  if (w_misaligned) begin
                     r_data_valid <= 1'b1;
                     r_err        <= 1'b1;
                     r_data       <= '0;
                     r_hold_cnt   <= LP_HOLD;
                     r_state      <= ST_HOLD;
                  end else begin
                     r_addr    <= rd_addr_i;
                     r_size    <= rd_size_i;
                     r_arvalid <= 1'b1;
                     r_state   <= ST_ADDR;
                  end
               end
            end
            ST_ADDR: begin
               if (axi_arready_i) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (axi_rvalid_i) begin
                  r_rready     <= 1'b0;
                  r_data       <= w_aligned;
                  r_err        <= w_resp_err;
                  r_data_valid <= 1'b1;
                  r_hold_cnt   <= LP_HOLD;
                  r_state      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // Leaving on the 1->0 step keeps exactly HOLD_CYCLES cycles in HOLD
               if (r_hold_cnt <= 3'd1) begin
                  r_hold_cnt <= '0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt - 3'd1;
               end
            end
            default: begin
               r_arvalid <= 1'b0;
               r_rready  <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_data_valid_o = r_data_valid;
   assign rd_data_o       = r_data;
   assign rd_err_o        = r_err;
   assign axi_arvalid_o   = r_arvalid;
   assign axi_araddr_o    = r_addr;
   assign axi_arid_o      = AXI_ID;
   assign axi_arlen_o     = 8'd0;
   assign axi_arsize_o    = {1'b0, r_size};
   assign axi_arburst_o   = BURST_INCR;
   assign axi_rready_o    = r_rready;

endmodule

// File: tb/tb_ysyx_22040759_axi_rd_master.sv
// Directed bench for the AXI read master with a small inline AXI slave.
module tb_ysyx_22040759_axi_rd_master;
   import ysyx_22040759_axi_pkg::*;

   localparam int unsigned HOLD = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_addr_valid_i;
   logic [63:0] rd_addr_i;
   logic [1:0]  rd_size_i;
   logic        rd_data_valid_o;
   logic [63:0] rd_data_o;
   logic        rd_err_o;
   logic        axi_arvalid_o;
   logic        axi_arready_i;
   logic [63:0] axi_araddr_o;
   logic [3:0]  axi_arid_o;
   logic [7:0]  axi_arlen_o;
   logic [2:0]  axi_arsize_o;
   logic [1:0]  axi_arburst_o;
   logic        axi_rvalid_i;
   logic        axi_rready_o;
   logic [63:0] axi_rdata_i;
   logic [1:0]  axi_rresp_i;
   logic        axi_rlast_i;
   logic [3:0]  axi_rid_i;

   int n_chk = 0;
   int n_err = 0;

   // Per-transaction observations
   int          o_pulses;
   int          o_pulse_cyc;
   int          o_ar_first;
   int          o_ar_cnt;
   int          o_ar2_cyc;
   logic [63:0] o_data;
   logic        o_err;
   logic        o_ar_ok;

   always #5 clk = ~clk;

   ysyx_22040759_axi_rd_master #(
      .AXI_ID      (4'd0),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rd_addr_valid_i (rd_addr_valid_i),
      .rd_addr_i       (rd_addr_i),
      .rd_size_i       (rd_size_i),
      .rd_data_valid_o (rd_data_valid_o),
      .rd_data_o       (rd_data_o),
      .rd_err_o        (rd_err_o),
      .axi_arvalid_o   (axi_arvalid_o),
      .axi_arready_i   (axi_arready_i),
      .axi_araddr_o    (axi_araddr_o),
      .axi_arid_o      (axi_arid_o),
      .axi_arlen_o     (axi_arlen_o),
      .axi_arsize_o    (axi_arsize_o),
      .axi_arburst_o   (axi_arburst_o),
      .axi_rvalid_i    (axi_rvalid_i),
      .axi_rready_o    (axi_rready_o),
      .axi_rdata_i     (axi_rdata_i),
      .axi_rresp_i     (axi_rresp_i),
      .axi_rlast_i     (axi_rlast_i),
      .axi_rid_i       (axi_rid_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one request and play the slave for a fixed window; cycle 1 is the
   // cycle after the edge that first samples the request.
   task automatic run_read(input logic [63:0] addr, input logic [1:0] size,
                           input int ar_wait, input int r_wait,
                           input logic [63:0] rdata, input logic [1:0] rresp,
                           input logic [3:0] rid, input logic rlast,
                           input logic keep_req);
      int ar_n;
      int r_n;
      ar_n = 0;
      r_n  = 0;
      o_pulses = 0; o_pulse_cyc = -1; o_ar_first = -1; o_ar_cnt = 0; o_ar2_cyc = -1;
      o_data = '0; o_err = 1'b0; o_ar_ok = 1'b1;
      axi_rdata_i = rdata; axi_rresp_i = rresp; axi_rid_i = rid; axi_rlast_i = rlast;
      rd_addr_valid_i = 1'b1; rd_addr_i = addr; rd_size_i = size;
      for (int c = 1; c <= 24; c++) begin
         tick;
         axi_arready_i = 1'b0;
         axi_rvalid_i  = 1'b0;
         if (axi_arvalid_o) begin
            o_ar_cnt++;
            if (o_ar_first < 0) o_ar_first = c;
            if (o_pulses > 0 && o_ar2_cyc < 0) begin
               o_ar2_cyc = c;
               rd_addr_valid_i = 1'b0;
            end
            if (axi_araddr_o !== addr || axi_arsize_o !== {1'b0, size} || axi_arlen_o !== 8'd0 ||
                axi_arburst_o !== 2'b01 || axi_arid_o !== 4'd0)
               o_ar_ok = 1'b0;
            ar_n++;
            if (ar_n > ar_wait) begin
               axi_arready_i = 1'b1;
               ar_n = 0;
            end
         end
         if (axi_rready_o) begin
            r_n++;
            if (r_n > r_wait) begin
               axi_rvalid_i = 1'b1;
               r_n = 0;
            end
         end
         if (rd_data_valid_o) begin
            o_pulses++;
            if (o_pulse_cyc < 0) begin
               o_pulse_cyc = c;
               o_data = rd_data_o;
               o_err  = rd_err_o;
            end
            if (!keep_req) rd_addr_valid_i = 1'b0;
         end
      end
      rd_addr_valid_i = 1'b0;
      axi_arready_i   = 1'b0;
      axi_rvalid_i    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic found;
      rst = 1'b1;
      rd_addr_valid_i = 1'b0; rd_addr_i = '0; rd_size_i = '0;
      axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rdata_i = '0;
      axi_rresp_i = '0; axi_rlast_i = 1'b0; axi_rid_i = '0;
      repeat (3) tick;
      chk("rst_arvalid", 64'(axi_arvalid_o), 64'd0);
      chk("rst_rready",  64'(axi_rready_o), 64'd0);
      chk("rst_valid",   64'(rd_data_valid_o), 64'd0);
      chk("rst_err",     64'(rd_err_o), 64'd0);
      chk("rst_data",    rd_data_o, 64'd0);
      chk("rst_araddr",  axi_araddr_o, 64'd0);
      rst = 1'b0;
      tick;

      // Dword, zero wait states
      run_read(64'h8000_0000, 2'b11, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 4'd0, 1'b1, 1'b0);
      chk("d_ar_first",  64'(o_ar_first), 64'd1);
      chk("d_ar_cnt",    64'(o_ar_cnt), 64'd1);
      chk("d_ar_fields", 64'(o_ar_ok), 64'd1);
      chk("d_pulse_cyc", 64'(o_pulse_cyc), 64'd3);
      chk("d_pulses",    64'(o_pulses), 64'd1);
      chk("d_data",      o_data, 64'h1122_3344_5566_7788);
      chk("d_err",       64'(o_err), 64'd0);

      // Byte at offset 5
      run_read(64'h8000_0005, 2'b00, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 4'd0, 1'b1, 1'b0);
      chk("b_data",   o_data, 64'h33);
      chk("b_err",    64'(o_err), 64'd0);
      chk("b_pulses", 64'(o_pulses), 64'd1);

      // Half at offset 6
      run_read(64'h8000_0006, 2'b01, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 4'd0, 1'b1, 1'b0);
      chk("h_data",      o_data, 64'h1122);
      chk("h_ar_fields", 64'(o_ar_ok), 64'd1);

      // Backpressure: arready after 4 cycles, rvalid after 3 rready cycles
      run_read(64'h8000_0010, 2'b10, 4, 3, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 4'd0, 1'b1, 1'b0);
      chk("bp_ar_cnt",    64'(o_ar_cnt), 64'd5);
      chk("bp_ar_fields", 64'(o_ar_ok), 64'd1);
      chk("bp_pulse_cyc", 64'(o_pulse_cyc), 64'd10);
      chk("bp_pulses",    64'(o_pulses), 64'd1);
      chk("bp_data",      o_data, 64'hCAFE_F00D);
      chk("bp_err",       64'(o_err), 64'd0);

      // Misaligned word: no AXI access, error pulse with zero data
      run_read(64'h8000_0002, 2'b10, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 4'd0, 1'b1, 1'b0);
      chk("mis_ar_cnt",    64'(o_ar_cnt), 64'd0);
      chk("mis_pulses",    64'(o_pulses), 64'd1);
      chk("mis_pulse_cyc", 64'(o_pulse_cyc), 64'd1);
      chk("mis_err",       64'(o_err), 64'd1);
      chk("mis_data",      o_data, 64'd0);

      // SLVERR still delivers data
      run_read(64'h8000_0008, 2'b11, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b10, 4'd0, 1'b1, 1'b0);
      chk("slv_err",    64'(o_err), 64'd1);
      chk("slv_data",   o_data, 64'h0123_4567_89AB_CDEF);
      chk("slv_pulses", 64'(o_pulses), 64'd1);

      // Wrong RID
      run_read(64'h8000_0018, 2'b11, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 4'd5, 1'b1, 1'b0);
      chk("rid_err", 64'(o_err), 64'd1);

      // Missing RLAST
      run_read(64'h8000_0020, 2'b11, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 4'd0, 1'b0, 1'b0);
      chk("rlast_err", 64'(o_err), 64'd1);

      // Request held high: next AR must wait out the hold-off
      run_read(64'h8000_0028, 2'b11, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 4'd0, 1'b1, 1'b1);
      chk("hold_pulses",  64'(o_pulses), 64'd2);
      chk("hold_ar2",     64'(o_ar2_cyc > 0), 64'd1);
      chk("hold_gap",     64'((o_ar2_cyc - o_pulse_cyc) >= int'(HOLD + 1)), 64'd1);

      // Reset while in DATA
      rd_addr_valid_i = 1'b1; rd_addr_i = 64'h8000_0040; rd_size_i = 2'b11;
      axi_arready_i = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick;
         if (axi_rready_o) found = 1'b1;
      end
      chk("mid_reach_data", 64'(found), 64'd1);
      rd_addr_valid_i = 1'b0;
      axi_arready_i   = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mid_arvalid", 64'(axi_arvalid_o), 64'd0);
      chk("mid_rready",  64'(axi_rready_o), 64'd0);
      chk("mid_valid",   64'(rd_data_valid_o), 64'd0);
      chk("mid_state",   64'(dut.r_state), 64'(ST_IDLE));
      repeat (3) tick;
      chk("post_arvalid", 64'(axi_arvalid_o), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
